// File: rtl/lsu_bus_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// lsu_bus_ctrl_pkg
// Shared constants for the MEM-stage load/store unit:
//   - RV32I load/store funct3 encodings (access size and signedness)
//   - LSU FSM state encoding
//   - pipeline default NOP
//   - helper that classifies an access as misaligned
// ----------------------------------------------------------------------------
package lsu_bus_ctrl_pkg;

    localparam logic [2:0] F3_B  = 3'b000;   // lb / sb
    localparam logic [2:0] F3_H  = 3'b001;   // lh / sh
    localparam logic [2:0] F3_W  = 3'b010;   // lw / sw
    localparam logic [2:0] F3_BU = 3'b100;   // lbu
    localparam logic [2:0] F3_HU = 3'b101;   // lhu

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_DONE = 2'd2
    } lsu_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Undefined size encodings (011, 110, 111) are reported as misaligned so
    // they never reach the bus.
    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] lane);
        logic mis;
        case (f3)
            F3_B, F3_BU: mis = 1'b0;
            F3_H, F3_HU: mis = lane[0];
            F3_W:        mis = (lane != 2'b00);
            default:     mis = 1'b1;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_bus_ctrl_if.sv
// ----------------------------------------------------------------------------
// lsu_bus_ctrl_if
// Bundles the pipeline-side memory controls and the req/ready bus of the LSU.
//   Pipeline in : i_mem_read, i_mem_write, i_funct3, i_addr, i_wdata
//   Pipeline out: o_stall, o_rdata, o_done, o_misaligned, o_bus_err
//   Bus out     : o_bus_req, o_bus_we, o_bus_addr, o_bus_be, o_bus_wdata
//   Bus in      : i_bus_ready, i_bus_rdata
// modport master : the LSU itself
// modport slave  : the environment (pipeline + bus target)
// ----------------------------------------------------------------------------
interface lsu_bus_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              i_mem_read;
    logic              i_mem_write;
    logic [2:0]        i_funct3;
    logic [ADDR_W-1:0] i_addr;
    logic [31:0]       i_wdata;

    logic              o_stall;
    logic [31:0]       o_rdata;
    logic              o_done;
    logic              o_misaligned;
    logic              o_bus_err;

    logic              o_bus_req;
    logic              o_bus_we;
    logic [ADDR_W-1:0] o_bus_addr;
    logic [3:0]        o_bus_be;
    logic [31:0]       o_bus_wdata;
    logic              i_bus_ready;
    logic [31:0]       i_bus_rdata;

    modport master (
        input  i_mem_read, i_mem_write, i_funct3, i_addr, i_wdata,
        input  i_bus_ready, i_bus_rdata,
        output o_stall, o_rdata, o_done, o_misaligned, o_bus_err,
        output o_bus_req, o_bus_we, o_bus_addr, o_bus_be, o_bus_wdata
    );

    modport slave (
        output i_mem_read, i_mem_write, i_funct3, i_addr, i_wdata,
        output i_bus_ready, i_bus_rdata,
        input  o_stall, o_rdata, o_done, o_misaligned, o_bus_err,
        input  o_bus_req, o_bus_we, o_bus_addr, o_bus_be, o_bus_wdata
    );

endinterface

// File: rtl/lsu_bus_ctrl_lane_fmt.sv
// ----------------------------------------------------------------------------
// lsu_lane_fmt
// Purely combinational RV32I lane formatter shared by store and load paths.
//   funct3_i      : access size / signedness
//   lane_i        : byte address bits [1:0]
//   wdata_i       : raw store data from the pipeline
//   rdata_i       : raw word returned by the bus
//   be_o          : store byte enables
//   bus_wdata_o   : store data replicated across the active lanes
//   load_data_o   : lane-selected, sign/zero extended load data
//   misaligned_o  : access cannot be performed as a single aligned word access
// ----------------------------------------------------------------------------
module lsu_lane_fmt
    import lsu_bus_ctrl_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  lane_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] bus_wdata_o,
    output logic [31:0] load_data_o,
    output logic        misaligned_o
);

    logic [31:0] shifted;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        shifted      = rdata_i >> {lane_i, 3'b000};
        byte_sel     = shifted[7:0];
        half_sel     = lane_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        misaligned_o = f3_misaligned(funct3_i, lane_i);

        be_o         = 4'b0000;
        bus_wdata_o  = 32'h0;
        load_data_o  = 32'h0;

        case (funct3_i)
            F3_B, F3_BU: begin
                be_o        = 4'b0001 << lane_i;
                bus_wdata_o = {4{wdata_i[7:0]}};
                // funct3[2] selects the unsigned variant
                load_data_o = funct3_i[2] ? {24'h0, byte_sel}
                                          : {{24{byte_sel[7]}}, byte_sel};
            end
            F3_H, F3_HU: begin
                be_o        = lane_i[1] ? 4'b1100 : 4'b0011;
                bus_wdata_o = {2{wdata_i[15:0]}};
                load_data_o = funct3_i[2] ? {16'h0, half_sel}
                                          : {{16{half_sel[15]}}, half_sel};
            end
            F3_W: begin
                be_o        = 4'b1111;
                bus_wdata_o = wdata_i;
                load_data_o = rdata_i;
            end
            default: begin
                be_o        = 4'b0000;
                bus_wdata_o = 32'h0;
                load_data_o = 32'h0;
            end
        endcase
    end

endmodule

// File: rtl/lsu_bus_ctrl.sv
// ----------------------------------------------------------------------------
// lsu_bus_ctrl
// Multi-cycle MEM-stage load/store unit acting as a req/ready bus master.
// An aligned access is latched in IDLE, held on the bus in BUS until ready
// (or a timeout abort), and reported for one cycle in DONE. The pipeline is
// stalled from the IDLE launch cycle through the last BUS cycle.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : lsu_bus_ctrl_if.master (pipeline controls + bus signals)
// Parameters:
//   ADDR_W  : byte address width
//   TIMEOUT : BUS cycles to wait for ready before aborting (0 = never)
// ----------------------------------------------------------------------------
module lsu_bus_ctrl
    import lsu_bus_ctrl_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          reset,
    lsu_bus_ctrl_if.master bus
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    // The abort fires on the TIMEOUT-th ready-less BUS cycle, i.e. when
    // TIMEOUT-1 such cycles have already been counted.
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    lsu_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [3:0]        be_q;
    logic [31:0]       wdata_q;
    logic [2:0]        funct3_q;
    logic [1:0]        lane_q;
    logic [31:0]       rdata_q;
    logic              err_q;
    logic [CNT_W-1:0]  wait_cnt_q;

    logic        acc;
    logic        in_bus;
    logic        launch;
    logic        complete;
    logic        timeout_hit;
    logic [2:0]  fmt_f3;
    logic [1:0]  fmt_lane;
    logic [3:0]  fmt_be;
    logic [31:0] fmt_wdata;
    logic [31:0] fmt_load;
    logic        fmt_mis;

    assign acc    = bus.i_mem_read | bus.i_mem_write;
    assign in_bus = (state_q == S_BUS);

    // One formatter serves both directions: in IDLE it formats the incoming
    // store and checks alignment, in BUS it extracts the load from the
    // returned word using the latched size and lane.
    assign fmt_f3   = in_bus ? funct3_q : bus.i_funct3;
    assign fmt_lane = in_bus ? lane_q   : bus.i_addr[1:0];

    lsu_lane_fmt u_lane_fmt (
        .funct3_i     (fmt_f3),
        .lane_i       (fmt_lane),
        .wdata_i      (bus.i_wdata),
        .rdata_i      (bus.i_bus_rdata),
        .be_o         (fmt_be),
        .bus_wdata_o  (fmt_wdata),
        .load_data_o  (fmt_load),
        .misaligned_o (fmt_mis)
    );

    assign launch      = (state_q == S_IDLE) && acc && !fmt_mis;
    assign complete    = in_bus && bus.i_bus_ready;
    assign timeout_hit = (TIMEOUT != 0) && in_bus && !bus.i_bus_ready
                         && (wait_cnt_q >= TO_LAST);

    // ---------------- state register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (launch) state_d = S_BUS;
            S_BUS:   if (complete || timeout_hit) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;   // same instruction; inputs ignored
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- access latches, result, wait counter ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q     <= '0;
            we_q       <= 1'b0;
            be_q       <= 4'h0;
            wdata_q    <= 32'h0;
            funct3_q   <= 3'b000;
            lane_q     <= 2'b00;
            rdata_q    <= 32'h0;
            err_q      <= 1'b0;
            wait_cnt_q <= '0;
        end else begin
            if (launch) begin
                addr_q     <= {bus.i_addr[ADDR_W-1:2], 2'b00};
                we_q       <= bus.i_mem_write;   // read+write counts as write
                be_q       <= bus.i_mem_write ? fmt_be : 4'hF;
                wdata_q    <= bus.i_mem_write ? fmt_wdata : 32'h0;
                funct3_q   <= bus.i_funct3;
                lane_q     <= bus.i_addr[1:0];
                err_q      <= 1'b0;
                wait_cnt_q <= '0;
            end
            if (complete) begin
                rdata_q <= we_q ? 32'h0 : fmt_load;
            end else if (timeout_hit) begin
                rdata_q <= 32'h0;
                err_q   <= 1'b1;
            end
            if (in_bus && !bus.i_bus_ready && (wait_cnt_q != '1)) begin
                wait_cnt_q <= wait_cnt_q + 1'b1;
            end
        end
    end

    // ---------------- outputs ----------------
    // Gated by reset so every output is low for as long as reset is held,
    // even if the pipeline keeps presenting an access.
    always_comb begin
        bus.o_stall      = 1'b0;
        bus.o_rdata      = 32'h0;
        bus.o_done       = 1'b0;
        bus.o_misaligned = 1'b0;
        bus.o_bus_err    = 1'b0;
        bus.o_bus_req    = 1'b0;
        bus.o_bus_we     = 1'b0;
        bus.o_bus_addr   = '0;
        bus.o_bus_be     = 4'h0;
        bus.o_bus_wdata  = 32'h0;
        if (!reset) begin
            case (state_q)
                S_IDLE: begin
                    if (acc) begin
                        if (fmt_mis) begin
                            bus.o_misaligned = 1'b1;
                            bus.o_done       = 1'b1;
                        end else begin
                            bus.o_stall = 1'b1;
                        end
                    end
                end
                S_BUS: begin
                    bus.o_stall     = 1'b1;
                    bus.o_bus_req   = 1'b1;
                    bus.o_bus_we    = we_q;
                    bus.o_bus_addr  = addr_q;
                    bus.o_bus_be    = be_q;
                    bus.o_bus_wdata = wdata_q;
                end
                S_DONE: begin
                    bus.o_done    = 1'b1;
                    bus.o_rdata   = rdata_q;
                    bus.o_bus_err = err_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// ----------------------------------------------------------------------------
// tb_lsu_bus_ctrl
// Directed bench for lsu_bus_ctrl (TIMEOUT=4). Inputs change 2 time units
// after each rising edge; outputs are sampled 1 unit later.
// ----------------------------------------------------------------------------
module tb_lsu_bus_ctrl;
    import lsu_bus_ctrl_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;
    int   stalls;

    always #5 clk = ~clk;

    lsu_bus_ctrl_if #(.ADDR_W(32)) bus_if ();

    lsu_bus_ctrl #(.ADDR_W(32), .TIMEOUT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata);
        bus_if.i_mem_read  = rd;
        bus_if.i_mem_write = wr;
        bus_if.i_funct3    = f3;
        bus_if.i_addr      = addr;
        bus_if.i_wdata     = wdata;
    endtask

    task automatic bus_resp(input logic ready, input logic [31:0] rdata);
        bus_if.i_bus_ready = ready;
        bus_if.i_bus_rdata = rdata;
    endtask

    // Zero-wait load: IDLE (stall) -> BUS (ready) -> DONE (data).
    task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] rdata, input logic [31:0] exp);
        drive(1'b1, 1'b0, f3, addr, 32'h0);
        bus_resp(1'b1, rdata);
        #1;
        chk1({tag, " idle stall"}, bus_if.o_stall, 1'b1);
        chk1({tag, " idle req"}, bus_if.o_bus_req, 1'b0);
        tick();
        chk1({tag, " bus req"}, bus_if.o_bus_req, 1'b1);
        chk32({tag, " bus addr"}, bus_if.o_bus_addr, {addr[31:2], 2'b00});
        chk32({tag, " bus be"}, {28'h0, bus_if.o_bus_be}, 32'hF);
        chk1({tag, " bus we"}, bus_if.o_bus_we, 1'b0);
        tick();
        chk1({tag, " done"}, bus_if.o_done, 1'b1);
        chk1({tag, " done stall"}, bus_if.o_stall, 1'b0);
        chk32({tag, " rdata"}, bus_if.o_rdata, exp);
        tick();
        drive(1'b0, 1'b0, F3_W, 32'h0, 32'h0);
        bus_resp(1'b0, 32'h0);
        $display("load %s addr=%08h bus=%08h -> %08h", tag, addr, rdata, bus_if.o_rdata);
    endtask

    initial begin
        // ---------------- reset ----------------
        reset = 1'b1;
        drive(1'b0, 1'b0, F3_W, 32'h0, 32'h0);
        bus_resp(1'b0, 32'h0);
        tick();
        tick();
        #1;
        chk1("rst stall", bus_if.o_stall, 1'b0);
        chk1("rst req", bus_if.o_bus_req, 1'b0);
        chk1("rst done", bus_if.o_done, 1'b0);
        chk32("rst rdata", bus_if.o_rdata, 32'h0);
        chk32("rst addr", bus_if.o_bus_addr, 32'h0);
        reset = 1'b0;
        #1;
        chk1("idle stall", bus_if.o_stall, 1'b0);
        tick();
        $display("reset done");

        // ---------------- zero-wait loads ----------------
        do_load("lw 100", F3_W, 32'h100, 32'hDEADBEEF, 32'hDEADBEEF);
        do_load("lb 103", F3_B, 32'h103, 32'h80FF00AA, 32'hFFFFFF80);
        do_load("lbu 103", F3_BU, 32'h103, 32'h80FF00AA, 32'h00000080);
        do_load("lhu 102", F3_HU, 32'h102, 32'h80FF00AA, 32'h000080FF);
        do_load("lh 102", F3_H, 32'h102, 32'h80FF00AA, 32'hFFFF80FF);
        do_load("lb 100", F3_B, 32'h100, 32'h80FF00AA, 32'hFFFFFFAA);
        do_load("lh 100", F3_H, 32'h100, 32'h80FF00AA, 32'h000000AA);
        do_load("lbu 101", F3_BU, 32'h101, 32'h80FF00AA, 32'h00000000);

        // ---------------- sh with 3 wait cycles ----------------
        drive(1'b0, 1'b1, F3_H, 32'h206, 32'h1234ABCD);
        bus_resp(1'b0, 32'h0);
        stalls = 0;
        #1;
        if (bus_if.o_stall) stalls++;
        for (int i = 1; i <= 4; i++) begin
            tick();
            if (i == 4) bus_resp(1'b1, 32'h0);
            #1;
            if (bus_if.o_stall) stalls++;
            chk1($sformatf("sh req c%0d", i), bus_if.o_bus_req, 1'b1);
            chk32($sformatf("sh addr c%0d", i), bus_if.o_bus_addr, 32'h204);
            chk32($sformatf("sh be c%0d", i), {28'h0, bus_if.o_bus_be}, 32'hC);
            chk32($sformatf("sh wdata c%0d", i), bus_if.o_bus_wdata, 32'hABCDABCD);
            chk1($sformatf("sh we c%0d", i), bus_if.o_bus_we, 1'b1);
        end
        tick();
        if (bus_if.o_stall) stalls++;
        chk1("sh done", bus_if.o_done, 1'b1);
        chk1("sh err", bus_if.o_bus_err, 1'b0);
        chk32("sh rdata", bus_if.o_rdata, 32'h0);
        chk32("sh stall cycles", stalls, 32'd5);
        tick();
        drive(1'b0, 1'b0, F3_W, 32'h0, 32'h0);
        bus_resp(1'b0, 32'h0);
        $display("store sh addr=206 stalls=%0d", stalls);

        // ---------------- sb with read+write both set ----------------
        drive(1'b1, 1'b1, F3_B, 32'h102, 32'h000000A5);
        bus_resp(1'b1, 32'hFFFFFFFF);
        #1;
        chk1("sb stall", bus_if.o_stall, 1'b1);
        tick();
        chk1("sb we", bus_if.o_bus_we, 1'b1);
        chk32("sb be", {28'h0, bus_if.o_bus_be}, 32'h4);
        chk32("sb wdata", bus_if.o_bus_wdata, 32'hA5A5A5A5);
        chk32("sb addr", bus_if.o_bus_addr, 32'h100);
        tick();
        chk1("sb done", bus_if.o_done, 1'b1);
        chk32("sb rdata", bus_if.o_rdata, 32'h0);
        tick();
        drive(1'b0, 1'b0, F3_W, 32'h0, 32'h0);
        bus_resp(1'b0, 32'h0);
        $display("store sb addr=102");

        // ---------------- misaligned ----------------
        drive(1'b1, 1'b0, F3_W, 32'h101, 32'h0);
        bus_resp(1'b1, 32'h12345678);
        #1;
        chk1("lw101 mis", bus_if.o_misaligned, 1'b1);
        chk1("lw101 done", bus_if.o_done, 1'b1);
        chk1("lw101 stall", bus_if.o_stall, 1'b0);
        chk1("lw101 req", bus_if.o_bus_req, 1'b0);
        chk32("lw101 rdata", bus_if.o_rdata, 32'h0);
        tick();
        drive(1'b0, 1'b1, F3_H, 32'h201, 32'h5555);
        #1;
        chk1("sh201 mis", bus_if.o_misaligned, 1'b1);
        chk1("sh201 req", bus_if.o_bus_req, 1'b0);
        tick();
        drive(1'b1, 1'b0, 3'b011, 32'h0, 32'h0);
        #1;
        chk1("f3 011 mis", bus_if.o_misaligned, 1'b1);
        chk1("f3 011 stall", bus_if.o_stall, 1'b0);
        tick();
        drive(1'b0, 1'b0, F3_W, 32'h0, 32'h0);
        bus_resp(1'b0, 32'h0);
        #1;
        chk1("post mis req", bus_if.o_bus_req, 1'b0);
        chk1("post mis pulse", bus_if.o_misaligned, 1'b0);
        chk1("post mis done", bus_if.o_done, 1'b0);
        tick();
        $display("misaligned cases done");

        // ---------------- timeout ----------------
        drive(1'b1, 1'b0, F3_W, 32'h300, 32'h0);
        bus_resp(1'b0, 32'hFFFFFFFF);
        #1;
        chk1("to stall", bus_if.o_stall, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk1($sformatf("to req c%0d", i), bus_if.o_bus_req, 1'b1);
        end
        tick();
        chk1("to req drop", bus_if.o_bus_req, 1'b0);
        chk1("to bus_err", bus_if.o_bus_err, 1'b1);
        chk1("to done", bus_if.o_done, 1'b1);
        chk32("to rdata", bus_if.o_rdata, 32'h0);
        chk1("to stall off", bus_if.o_stall, 1'b0);
        tick();
        drive(1'b0, 1'b0, F3_W, 32'h0, 32'h0);
        bus_resp(1'b0, 32'h0);
        #1;
        chk1("to err clear", bus_if.o_bus_err, 1'b0);
        tick();
        $display("timeout lw addr=300 aborted");

        // ---------------- reset during BUS ----------------
        drive(1'b1, 1'b0, F3_W, 32'h400, 32'h0);
        bus_resp(1'b0, 32'h0);
        tick();
        tick();
        #1;
        chk1("rb req before", bus_if.o_bus_req, 1'b1);
        reset = 1'b1;
        #1;
        chk1("rb req", bus_if.o_bus_req, 1'b0);
        chk1("rb stall", bus_if.o_stall, 1'b0);
        chk1("rb done", bus_if.o_done, 1'b0);
        chk32("rb addr", bus_if.o_bus_addr, 32'h0);
        chk32("rb be", {28'h0, bus_if.o_bus_be}, 32'h0);
        tick();
        tick();
        drive(1'b0, 1'b0, F3_W, 32'h0, 32'h0);
        reset = 1'b0;
        #1;
        chk1("rb idle req", bus_if.o_bus_req, 1'b0);
        drive(1'b0, 1'b1, F3_W, 32'h0, 32'hCAFEF00D);
        bus_resp(1'b1, 32'h0);
        #1;
        chk1("sw stall", bus_if.o_stall, 1'b1);
        tick();
        chk32("sw be", {28'h0, bus_if.o_bus_be}, 32'hF);
        chk32("sw wdata", bus_if.o_bus_wdata, 32'hCAFEF00D);
        chk32("sw addr", bus_if.o_bus_addr, 32'h0);
        chk1("sw we", bus_if.o_bus_we, 1'b1);
        tick();
        chk1("sw done", bus_if.o_done, 1'b1);
        chk32("sw rdata", bus_if.o_rdata, 32'h0);
        tick();
        drive(1'b0, 1'b0, F3_W, 32'h0, 32'h0);
        bus_resp(1'b0, 32'h0);
        $display("reset during BUS, then sw addr=0");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/lsu_bus_ctrl.md
Name: lsu_bus_ctrl

Overview:
- Multi-cycle load/store unit in the MEM stage. Replaces the zero-wait combinational data memory path with a req/ready bus master.
- Consumes the EX/MEM memory controls, address (ALU result) and store data. Performs RV32I byte/half/word lane formatting.
- Stalls the whole pipeline while a bus transfer is outstanding, then presents formatted load data for the MEM/WB register.

Parameters:
- ADDR_W, 32, byte address width on both the pipeline side and the bus side.
- TIMEOUT, 16, bus cycles to wait for i_bus_ready before aborting; 0 disables the timeout.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- i_mem_read  in  1  EX/MEM MemRead
- i_mem_write  in  1  EX/MEM MemWrite
- i_funct3  in  3  access size/sign (000 lb/sb, 001 lh/sh, 010 lw/sw, 100 lbu, 101 lhu)
- i_addr  in  ADDR_W  byte address (EX/MEM ALU result)
- i_wdata  in  32  store data (EX/MEM write data)
- o_stall  out  1  hold PC, IF/ID, ID/EX and EX/MEM; insert no bubble into MEM/WB
- o_rdata  out  32  formatted load data, valid while o_done=1
- o_done  out  1  one-cycle pulse: access finished (load data valid or store committed)
- o_misaligned  out  1  one-cycle pulse: misaligned access, no bus activity
- o_bus_err  out  1  one-cycle pulse: timeout abort
- o_bus_req  out  1  bus request
- o_bus_we  out  1  1 = write
- o_bus_addr  out  ADDR_W  word-aligned address, i_addr with [1:0] forced to 00
- o_bus_be  out  4  byte enables
- o_bus_wdata  out  32  lane-replicated store data
- i_bus_ready  in  1  transfer completes on the cycle where req && ready
- i_bus_rdata  in  32  read word, sampled on the completing cycle

Behaviour:
- Reset (asynchronous, active-high) forces the FSM to IDLE. All outputs go to 0: stall, done, misaligned, bus_err, bus_req, bus_we, bus_addr, bus_be, bus_wdata and rdata. A transfer in progress is dropped immediately; the bus must tolerate req falling without ready.
- Access request: acc = i_mem_read | i_mem_write. If both are set, the access is treated as a write.
- Alignment:
  - Half accesses (funct3 x01) are misaligned when addr[0]=1.
  - Word accesses are misaligned when addr[1:0]≠00.
  - Undefined funct3 values (011, 110, 111) are treated as misaligned.
- FSM states: IDLE, BUS, DONE.
- IDLE:
  - acc and aligned: o_stall=1 combinationally. Latch addr, we, be, wdata and funct3. Go to BUS.
  - acc and misaligned: o_misaligned=1 and o_done=1 for this cycle, o_rdata=0, no stall, no req. Stay in IDLE.
  - No acc: idle, all pulses 0.
- BUS:
  - o_bus_req=1 and o_stall=1. Address, we, be and wdata come from the latched values and are held stable until completion.
  - On req && ready: register the formatted load data, go to DONE.
  - If TIMEOUT≠0 and the wait counter reaches TIMEOUT with no ready: drop req, set registered rdata=0, flag the error, go to DONE.
- DONE:
  - o_stall=0, o_done=1, o_rdata valid. o_bus_err=1 if the access was aborted.
  - The pipeline advances at the end of this cycle.
  - i_mem_* are ignored in DONE (it is the same instruction). Go to IDLE unconditionally.
- Latency:
  - A zero-wait bus gives 2 stall cycles plus the DONE cycle.
  - Each cycle of ready=0 adds 1 cycle.
  - Back-to-back accesses: the next instruction is seen in IDLE on the cycle after DONE.
- Wait counter: cleared on entry to BUS, increments each BUS cycle with ready=0, saturates.
- Store formatting:
  - sb: be = 0001<<addr[1:0], wdata = {4{wdata[7:0]}}.
  - sh: be = 0011<<(2*addr[1]), wdata = {2{wdata[15:0]}}.
  - sw: be = 1111, wdata passed through.
  - Loads drive be = 1111.
- Load formatting:
  - lb/lbu select the byte lane by addr[1:0]; lb sign-extends, lbu zero-extends.
  - lh/lhu select the half lane by addr[1]; lh sign-extends, lhu zero-extends.
  - lw passes the word through.
  - Stores return rdata=0.
- A ready with req=0 is ignored.

Decomposition:
- Shared package (pipeline constants):
  - funct3 encodings F3_B/F3_H/F3_W/F3_BU/F3_HU.
  - FSM state encodings S_IDLE/S_BUS/S_DONE (2-bit).
  - Default NOP 32'h00000013.
- One combinational sub-module, lsu_lane_fmt: inputs funct3, addr[1:0], wdata and rdata; outputs be, bus_wdata, formatted load data and a misaligned flag. It is shared by the store path and the load path.
- The FSM, latches and timeout counter live in lsu_bus_ctrl.

Test Plan:
- lw at 0x100, ready=1 on the first BUS cycle, rdata 0xDEADBEEF → stall high for 2 cycles, bus_addr=0x100, be=1111, then a done pulse with o_rdata=0xDEADBEEF.
- lb at 0x103 with rdata 0x80FF00AA → o_rdata=0xFFFFFF80. lbu at the same address → 0x00000080. lhu at 0x102 → 0x000080FF.
- sh at 0x206 with wdata 0x1234ABCD, ready delayed 3 cycles → be=1100, bus_wdata=0xABCDABCD; req and address stay stable for 4 BUS cycles; total stall = 5.
- lw at 0x101 → a misaligned pulse and a done pulse in the same cycle, no req, stall=0, o_rdata=0.
- TIMEOUT=4 with ready held at 0 → req falls after 4 BUS cycles; DONE gives bus_err=1, done=1, o_rdata=0.
- reset asserted during the second BUS cycle → req, stall and all outputs go to 0 immediately. After release, a new sw at 0x0 completes normally with be=1111.
